gpio_in_conditioner: RTL and testbench

Per-bit input conditioner that sits directly upstream of the CoreGPIO instance and drives its `GPIO_IN` bus. It synchronises asynchronous pad inputs into the `PCLK` domain and debounces each bit with a programmable run-length filter. It also emits one-cycle rise/fall event pulses, so CoreGPIO edge interrupts fire once per settled transition rather than once per bounce.

---
 rtl/gpio_cond_pkg.sv | 16 +
 rtl/gpio_in_conditioner_if.sv | 22 ++
 rtl/gpio_in_debounce_bit.sv | 64 ++++++
 rtl/gpio_in_conditioner.sv | 46 ++++
 tb/tb_gpio_in_conditioner.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/gpio_cond_pkg.sv
// Shared constants and parameter-legality helpers for the GPIO input conditioner.
package gpio_cond_pkg;

  localparam int unsigned GPIO_COND_MAX_IO   = 32;
  localparam int unsigned GPIO_COND_MIN_SYNC = 2;
  localparam int unsigned GPIO_COND_MAX_SYNC = 3;

  function automatic bit gpio_cond_io_ok(input int unsigned io_num);
    return (io_num >= 1) && (io_num <= GPIO_COND_MAX_IO);
  endfunction

  function automatic bit gpio_cond_sync_ok(input int unsigned sync_stages);
    return (sync_stages >= GPIO_COND_MIN_SYNC) && (sync_stages <= GPIO_COND_MAX_SYNC);
  endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Pad-side inputs and CoreGPIO-side outputs of the input conditioner.
interface gpio_in_conditioner_if #(
  parameter int unsigned IO_NUM       = 8,
  parameter int unsigned DB_CNT_WIDTH = 4
);
  logic [IO_NUM-1:0]       PAD_IN;
  logic [DB_CNT_WIDTH-1:0] DB_LIMIT;
  logic [IO_NUM-1:0]       GPIO_IN;
  logic [IO_NUM-1:0]       RISE;
  logic [IO_NUM-1:0]       FALL;
  logic                    CHANGE;

  modport master (
    output PAD_IN, DB_LIMIT,
    input  GPIO_IN, RISE, FALL, CHANGE
  );

  modport slave (
    input  PAD_IN, DB_LIMIT,
    output GPIO_IN, RISE, FALL, CHANGE
  );
endinterface

// File: rtl/gpio_in_debounce_bit.sv
// One conditioned bit: synchroniser chain, run-length debounce counter,
// filtered level and registered rise/fall event flops.
module gpio_in_debounce_bit #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DB_CNT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pad_in,
  input  logic [DB_CNT_WIDTH-1:0] db_limit,
  output logic                    filt_o,
  output logic                    rise_o,
  output logic                    fall_o
);

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [DB_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    filt_q, filt_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic                    s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // >= rather than == so a lowered limit mid-run still terminates the count
    if (s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= db_limit) begin
      filt_d = s;
      cnt_d  = '0;
      rise_d = s;
      fall_d = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Per-bit pad synchroniser and debouncer feeding CoreGPIO GPIO_IN, with
// one-cycle rise/fall events and a combined CHANGE flag.
module gpio_in_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int unsigned IO_NUM       = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DB_CNT_WIDTH = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  gpio_in_conditioner_if.slave  bus
);

  if (!gpio_cond_io_ok(IO_NUM)) begin : g_bad_io_num
    $error("gpio_in_conditioner: IO_NUM %0d outside 1..%0d", IO_NUM, GPIO_COND_MAX_IO);
  end
  if (!gpio_cond_sync_ok(SYNC_STAGES)) begin : g_bad_sync
    $error("gpio_in_conditioner: SYNC_STAGES %0d must be 2 or 3", SYNC_STAGES);
  end

  logic [IO_NUM-1:0] filt_w;
  logic [IO_NUM-1:0] rise_w;
  logic [IO_NUM-1:0] fall_w;

  for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
    gpio_in_debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CNT_WIDTH (DB_CNT_WIDTH)
    ) u_bit (
      .clk      (PCLK),
      .rst_n    (PRESETN),
      .pad_in   (bus.PAD_IN[i]),
      .db_limit (bus.DB_LIMIT),
      .filt_o   (filt_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i])
    );
  end

  assign bus.GPIO_IN = filt_w;
  assign bus.RISE    = rise_w;
  assign bus.FALL    = fall_w;
  assign bus.CHANGE  = |(rise_w | fall_w);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner: IO_NUM=8, SYNC_STAGES=2, DB_LIMIT=3.
module tb_gpio_in_conditioner;

  logic PCLK;
  logic PRESETN;
  int unsigned n_cmp;
  int unsigned n_bad;
  logic [15:0] g_hist, r_hist, f_hist;

  gpio_in_conditioner_if #(.IO_NUM(8), .DB_CNT_WIDTH(4)) bus ();

  gpio_in_conditioner #(
    .IO_NUM       (8),
    .SYNC_STAGES  (2),
    .DB_CNT_WIDTH (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run n edges recording bit b of GPIO_IN/RISE/FALL after each; pad restored
  // to pad_after once hold_n edges have sampled pad_pulse.
  task automatic record(input int unsigned b, input logic [7:0] pad_pulse,
                        input logic [7:0] pad_after, input int unsigned hold_n,
                        input int unsigned n);
    g_hist = '0;
    r_hist = '0;
    f_hist = '0;
    bus.PAD_IN = pad_pulse;
    for (int unsigned t = 1; t <= n; t++) begin
      tick(1);
      if (t == hold_n) bus.PAD_IN = pad_after;
      g_hist[t] = bus.GPIO_IN[b];
      r_hist[t] = bus.RISE[b];
      f_hist[t] = bus.FALL[b];
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    PRESETN     = 1'b0;
    bus.PAD_IN  = 8'hFF;
    bus.DB_LIMIT = 4'd3;

    // 1. reset with pads high, then release
    tick(10);
    chk("rst_gpio",   32'(bus.GPIO_IN), 32'h00);
    chk("rst_rise",   32'(bus.RISE),    32'h00);
    chk("rst_fall",   32'(bus.FALL),    32'h00);
    chk("rst_change", 32'(bus.CHANGE),  32'h0);
    PRESETN = 1'b1;
    tick(5);
    chk("rel_gpio_e5", 32'(bus.GPIO_IN), 32'h00);
    tick(1);
    chk("rel_gpio_e6", 32'(bus.GPIO_IN), 32'hFF);
    chk("rel_rise_e6", 32'(bus.RISE),    32'hFF);
    chk("rel_chg_e6",  32'(bus.CHANGE),  32'h1);
    tick(1);
    chk("rel_rise_e7", 32'(bus.RISE),    32'h00);
    chk("rel_gpio_e7", 32'(bus.GPIO_IN), 32'hFF);

    // 2. clean step on bit 0
    bus.PAD_IN = 8'h00;
    tick(12);
    chk("step_base", 32'(bus.GPIO_IN), 32'h00);
    bus.PAD_IN = 8'h01;
    tick(5);
    chk("step_e5_gpio", 32'(bus.GPIO_IN), 32'h00);
    tick(1);
    chk("step_e6_gpio", 32'(bus.GPIO_IN), 32'h01);
    chk("step_e6_rise", 32'(bus.RISE),    32'h01);
    chk("step_e6_fall", 32'(bus.FALL),    32'h00);
    chk("step_e6_chg",  32'(bus.CHANGE),  32'h1);
    tick(1);
    chk("step_e7_rise", 32'(bus.RISE),    32'h00);
    chk("step_e7_chg",  32'(bus.CHANGE),  32'h0);
    chk("step_e7_gpio", 32'(bus.GPIO_IN), 32'h01);

    // 3. glitch rejection (3 cycles) and minimum pass (4 cycles) on bit 1
    record(1, 8'h03, 8'h01, 3, 14);
    chk("glitch3_gpio", 32'(g_hist), 32'h0000);
    chk("glitch3_rise", 32'(r_hist), 32'h0000);
    tick(4);
    record(1, 8'h03, 8'h01, 4, 14);
    chk("pulse4_gpio", 32'(g_hist), 32'h03C0);
    chk("pulse4_rise", 32'(r_hist), 32'h0040);
    chk("pulse4_fall", 32'(f_hist), 32'h0400);

    // 4. bypass: DB_LIMIT=0, single-cycle pulse on bit 4
    bus.DB_LIMIT = 4'd0;
    tick(2);
    record(4, 8'h11, 8'h01, 1, 8);
    chk("bypass_gpio", 32'(g_hist), 32'h0008);
    chk("bypass_rise", 32'(r_hist), 32'h0008);
    chk("bypass_fall", 32'(f_hist), 32'h0010);
    bus.DB_LIMIT = 4'd3;

    // 5. simultaneous rise on bit 2 and fall on bit 3
    bus.PAD_IN = 8'h08;
    tick(12);
    chk("simul_base", 32'(bus.GPIO_IN), 32'h08);
    bus.PAD_IN = 8'h04;
    tick(5);
    chk("simul_e5_chg", 32'(bus.CHANGE), 32'h0);
    tick(1);
    chk("simul_rise", 32'(bus.RISE),    32'h04);
    chk("simul_fall", 32'(bus.FALL),    32'h08);
    chk("simul_chg",  32'(bus.CHANGE),  32'h1);
    chk("simul_gpio", 32'(bus.GPIO_IN), 32'h04);

    // 6. reset asserted mid-count on bit 2
    bus.PAD_IN = 8'h81;
    tick(12);
    chk("midrst_base", 32'(bus.GPIO_IN), 32'h81);
    bus.PAD_IN = 8'h85;
    tick(4);
    chk("midrst_counting", 32'(bus.GPIO_IN), 32'h81);
    PRESETN = 1'b0;
    #1;
    chk("midrst_async_gpio", 32'(bus.GPIO_IN), 32'h00);
    chk("midrst_async_chg",  32'(bus.CHANGE),  32'h0);
    tick(2);
    PRESETN = 1'b1;
    tick(5);
    chk("midrst_e5_gpio", 32'(bus.GPIO_IN), 32'h00);
    tick(1);
    chk("midrst_e6_gpio", 32'(bus.GPIO_IN), 32'h85);
    chk("midrst_e6_rise", 32'(bus.RISE),    32'h85);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
